// File: rtl/cache_switch_pkg.sv
// Shared definitions for the cache bank switch controller: FSM state
// encoding and the width helper used to size bank and set-index fields.
package cache_switch_pkg;

    // Controller states; IDLE is zero so a cleared state register means idle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_WB     = 3'd2,
        ST_CLEAN  = 3'd3,
        ST_COMMIT = 3'd4
    } cs_state_t;

    // Widths of the optional statistics counters.
    localparam int unsigned STAT_CYC_W = 32;
    localparam int unsigned STAT_WB_W  = 16;

    // Field width for n items: clog2(n), never less than one bit.
    function automatic int unsigned cs_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_switch_stats.sv
// Saturating statistics counters for the cache bank switch controller.
// Counts cycles spent stalling the CPU and dirty lines written back.
module cache_switch_stats
    import cache_switch_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_busy,
    input  logic                  i_clean,
    output logic [STAT_CYC_W-1:0] o_switch_cycles,
    output logic [STAT_WB_W-1:0]  o_wb_count
);

    logic [STAT_CYC_W-1:0] r_cycles;
    logic [STAT_WB_W-1:0]  r_wb;

    // Accumulate stall cycles and completed write-backs, holding at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycles <= '0;
            r_wb     <= '0;
        end else begin
            if (i_busy && (r_cycles != '1)) begin
                r_cycles <= r_cycles + STAT_CYC_W'(1);
            end
            if (i_clean && (r_wb != '1)) begin
                r_wb <= r_wb + STAT_WB_W'(1);
            end
        end
    end

    assign o_switch_cycles = r_cycles;
    assign o_wb_count      = r_wb;

endmodule

// File: rtl/cache_switch_ctrl.sv
// Cache bank switch controller. On a context-switch request it stalls the
// CPU, walks every set of the outgoing bank, writes back valid dirty lines,
// clears their dirty bits and finally commits the new active bank.
// Optional feature macro: CACHE_SWITCH_STATS_EN adds SWITCH_CYCLES and
// WB_COUNT statistics outputs (cache_switch_stats sub-module).
//
// Handshake: WB_REQ is a level held for every WB cycle; the memory side
// answers with a one-cycle WB_ACK that is only honoured while in WB.
module cache_switch_ctrl
    import cache_switch_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 2,
    parameter  int unsigned SETS      = 8,
    localparam int unsigned BANK_W    = cs_width(NUM_BANKS),
    localparam int unsigned IDX_W     = cs_width(SETS)
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SWITCH_REQ,
    input  logic [BANK_W-1:0] SWITCH_BANK,
    output logic              BUSY,
    output logic [BANK_W-1:0] ACTIVE_BANK,
    output logic [BANK_W-1:0] SCAN_BANK,
    output logic [IDX_W-1:0]  SCAN_INDEX,
    input  logic              LINE_VALID,
    input  logic              LINE_DIRTY,
    output logic              WB_REQ,
    input  logic              WB_ACK,
    output logic              CLEAN_DIRTY,
    output logic              SWITCH_DONE,
    output cs_state_t         DBG_STATE
`ifdef CACHE_SWITCH_STATS_EN
    ,
    output logic [STAT_CYC_W-1:0] SWITCH_CYCLES,
    output logic [STAT_WB_W-1:0]  WB_COUNT
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    cs_state_t         r_state;
    cs_state_t         w_state_nxt;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_index_nxt;
    logic [BANK_W-1:0] r_active_bank;
    logic [BANK_W-1:0] w_active_nxt;
    logic [BANK_W-1:0] r_target;
    logic [BANK_W-1:0] w_target_nxt;
    logic              w_last;
    logic              w_wb_needed;

    assign w_last      = (r_index == LAST_IDX);
    // Invalid lines are never written back even if their dirty bit is set.
    assign w_wb_needed = LINE_VALID & LINE_DIRTY;

    // State, set index, active bank and latched target registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_active_bank <= '0;
            r_target      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_index       <= w_index_nxt;
            r_active_bank <= w_active_nxt;
            r_target      <= w_target_nxt;
        end
    end

    // Next-state and datapath updates; requests outside IDLE are dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_active_nxt = r_active_bank;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (SWITCH_REQ) begin
                    w_target_nxt = SWITCH_BANK;
                    if (SWITCH_BANK != r_active_bank) begin
                        w_index_nxt = '0;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        // Same bank: nothing to flush, just acknowledge.
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_SCAN: begin
                if (w_wb_needed) begin
                    w_state_nxt = ST_WB;
                end else if (w_last) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_index_nxt = r_index + IDX_W'(1);
                end
            end
            ST_WB: begin
                if (WB_ACK) begin
                    w_state_nxt = ST_CLEAN;
                end
            end
            ST_CLEAN: begin
                if (w_last) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_index_nxt = r_index + IDX_W'(1);
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_COMMIT: begin
                w_active_nxt = r_target;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    assign BUSY        = (r_state != ST_IDLE);
    assign WB_REQ      = (r_state == ST_WB);
    assign CLEAN_DIRTY = (r_state == ST_CLEAN);
    assign SWITCH_DONE = (r_state == ST_COMMIT);
    assign ACTIVE_BANK = r_active_bank;
    // The outgoing bank is the active one until the commit cycle ends.
    assign SCAN_BANK   = r_active_bank;
    assign SCAN_INDEX  = r_index;
    assign DBG_STATE   = r_state;

`ifdef CACHE_SWITCH_STATS_EN
    cache_switch_stats u_stats (
        .i_clk           (CLK),
        .i_rst_n         (RESET),
        .i_busy          (BUSY),
        .i_clean         (CLEAN_DIRTY),
        .o_switch_cycles (SWITCH_CYCLES),
        .o_wb_count      (WB_COUNT)
    );
`endif

endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Self-checking bench for cache_switch_ctrl (8 sets, 2 banks). A trace
// model expands each switch into the per-cycle outputs the controller must
// show; the bench also emulates the tag array and the write-back memory.
// Statistics checks are enabled with CACHE_SWITCH_STATS_EN.
module tb_cache_switch_ctrl;
    import cache_switch_pkg::*;

    localparam int SETS  = 8;
    localparam int EXP_W = 9;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        SWITCH_REQ = 1'b0;
    logic [0:0]  SWITCH_BANK = 1'b0;
    logic        BUSY;
    logic [0:0]  ACTIVE_BANK;
    logic [0:0]  SCAN_BANK;
    logic [2:0]  SCAN_INDEX;
    logic        LINE_VALID;
    logic        LINE_DIRTY;
    logic        WB_REQ;
    logic        WB_ACK = 1'b0;
    logic        CLEAN_DIRTY;
    logic        SWITCH_DONE;
    cs_state_t   DBG_STATE;
`ifdef CACHE_SWITCH_STATS_EN
    logic [31:0] SWITCH_CYCLES;
    logic [15:0] WB_COUNT;
`endif

    cache_switch_ctrl #(.NUM_BANKS(2), .SETS(SETS)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SWITCH_REQ  (SWITCH_REQ),
        .SWITCH_BANK (SWITCH_BANK),
        .BUSY        (BUSY),
        .ACTIVE_BANK (ACTIVE_BANK),
        .SCAN_BANK   (SCAN_BANK),
        .SCAN_INDEX  (SCAN_INDEX),
        .LINE_VALID  (LINE_VALID),
        .LINE_DIRTY  (LINE_DIRTY),
        .WB_REQ      (WB_REQ),
        .WB_ACK      (WB_ACK),
        .CLEAN_DIRTY (CLEAN_DIRTY),
        .SWITCH_DONE (SWITCH_DONE),
        .DBG_STATE   (DBG_STATE)
`ifdef CACHE_SWITCH_STATS_EN
        ,
        .SWITCH_CYCLES (SWITCH_CYCLES),
        .WB_COUNT      (WB_COUNT)
`endif
    );

    // Clock: posedges at 5, 15, 25 ...; the bench samples on negedges.
    always #5 CLK = ~CLK;

    // Tag array emulation.
    bit valid_m [2][SETS];
    bit dirty_m [2][SETS];
    assign LINE_VALID = valid_m[SCAN_BANK][SCAN_INDEX];
    assign LINE_DIRTY = dirty_m[SCAN_BANK][SCAN_INDEX];

    // Scoreboard: expected {busy,wb,clean,done,idx,active,scan_bank} per cycle.
    logic [EXP_W-1:0] exp_q[$];
    int               l_q[$];
    logic [0:0]       m_active;
    logic [2:0]       m_idx;
    logic [31:0]      m_cycles;
    logic [31:0]      m_wb;

    // Write-back responder and observation counters.
    int wb_cnt;
    int cur_l;
    int busy_run;
    int last_busy;
    int done_at;
    int wb_at [SETS];
    int clean_at [SETS];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk(input logic b, input logic w, input logic c,
                                            input logic d, input logic [2:0] idx,
                                            input logic [0:0] bank);
        return {b, w, c, d, idx, bank, bank};
    endfunction

    task automatic clear_obs();
        last_busy = 0;
        done_at   = 0;
        for (int i = 0; i < SETS; i++) begin
            wb_at[i]    = 0;
            clean_at[i] = 0;
        end
    endtask

    // Issue a request and append the complete expected trace of the switch.
    // fixed_l > 0 forces every write-back to take that many WB cycles.
    task automatic start_switch(input logic [0:0] tgt, input int fixed_l);
        logic [0:0] old;
        int         l;
        old = m_active;
        SWITCH_REQ  = 1'b1;
        SWITCH_BANK = tgt;
        if (tgt == old) begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, m_idx, old));
        end else begin
            for (int i = 0; i < SETS; i++) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'(i), old));
                if (valid_m[old][i] && dirty_m[old][i]) begin
                    l = (fixed_l > 0) ? fixed_l : int'($urandom_range(1, 4));
                    l_q.push_back(l);
                    repeat (l) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), old));
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'(i), old));
                end
            end
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'(SETS - 1), old));
            m_idx = 3'(SETS - 1);
        end
        m_active = tgt;
    endtask

    // One clock: compare on the negedge, then act as tag array / memory / CPU.
    task automatic tick(input bit stray);
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] g;
        @(negedge CLK);
        e = (exp_q.size() > 0) ? exp_q.pop_front()
                               : mk(1'b0, 1'b0, 1'b0, 1'b0, m_idx, m_active);
        g = {BUSY, WB_REQ, CLEAN_DIRTY, SWITCH_DONE, SCAN_INDEX, ACTIVE_BANK, SCAN_BANK};
        check("cycle", 32'(g), 32'(e));
`ifdef CACHE_SWITCH_STATS_EN
        check("switch_cycles", SWITCH_CYCLES, m_cycles);
        check("wb_count", 32'(WB_COUNT), m_wb);
`endif
        if (e[8] && (m_cycles != '1)) m_cycles++;
        if (e[6] && (m_wb != 32'hFFFF)) m_wb++;

        if (BUSY) begin
            busy_run++;
            if (SWITCH_DONE) done_at = busy_run;
        end else if (busy_run > 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
        if (WB_REQ) wb_at[SCAN_INDEX]++;
        if (CLEAN_DIRTY) begin
            clean_at[SCAN_INDEX]++;
            dirty_m[SCAN_BANK][SCAN_INDEX] = 1'b0;
        end

        SWITCH_REQ = 1'b0;
        WB_ACK     = 1'b0;
        if (WB_REQ) begin
            if (wb_cnt == 0) cur_l = (l_q.size() > 0) ? l_q.pop_front() : 1;
            wb_cnt++;
            if (wb_cnt == cur_l) WB_ACK = 1'b1;
        end else begin
            wb_cnt = 0;
        end

        if (stray) begin
            SWITCH_REQ  = 1'b1;
            SWITCH_BANK = ~m_active;
            WB_ACK      = 1'b1;
        end
    endtask

    // Run until the expected trace drains, plus one idle cycle.
    task automatic run_out(input int stray_at);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            tick(k == stray_at);
            k++;
        end
        tick(1'b0);
    endtask

    // 4 ns asynchronous reset pulse starting 2 ns after a negedge.
    task automatic async_reset();
        #2 RESET = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_wb_req", 32'(WB_REQ), 32'd0);
        check("rst_clean", 32'(CLEAN_DIRTY), 32'd0);
        check("rst_done", 32'(SWITCH_DONE), 32'd0);
        check("rst_index", 32'(SCAN_INDEX), 32'd0);
        check("rst_active", 32'(ACTIVE_BANK), 32'd0);
        check("rst_scan_bank", 32'(SCAN_BANK), 32'd0);
`ifdef CACHE_SWITCH_STATS_EN
        check("rst_switch_cycles", SWITCH_CYCLES, 32'd0);
        check("rst_wb_count", 32'(WB_COUNT), 32'd0);
`endif
        exp_q.delete();
        l_q.delete();
        wb_cnt     = 0;
        busy_run   = 0;
        m_active   = 1'b0;
        m_idx      = 3'd0;
        m_cycles   = 32'd0;
        m_wb       = 32'd0;
        SWITCH_REQ = 1'b0;
        WB_ACK     = 1'b0;
        #3 RESET = 1'b1;
    endtask

    initial begin
        int sum;
        m_active = 1'b0;
        m_idx    = 3'd0;
        m_cycles = 32'd0;
        m_wb     = 32'd0;
        wb_cnt   = 0;
        cur_l    = 1;
        busy_run = 0;
        clear_obs();
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < SETS; s++) begin
                valid_m[b][s] = 1'b0;
                dirty_m[b][s] = 1'b0;
            end
        end

        // Power-on reset.
        repeat (3) tick(1'b0);
        RESET = 1'b1;
        tick(1'b0);

        // Clean switch 0 -> 1.
        clear_obs();
        start_switch(1'b1, 0);
        run_out(-1);
        sum = 0;
        for (int i = 0; i < SETS; i++) sum += wb_at[i];
        check("clean_busy_len", 32'(last_busy), 32'd9);
        check("clean_done_pos", 32'(done_at), 32'd9);
        check("clean_active", 32'(ACTIVE_BANK), 32'd1);
        check("clean_no_wb", 32'(sum), 32'd0);

        // Dirty write-back 1 -> 0: sets 2 and 7 dirty, set 4 dirty but invalid.
        valid_m[1][2] = 1'b1; dirty_m[1][2] = 1'b1;
        valid_m[1][7] = 1'b1; dirty_m[1][7] = 1'b1;
        valid_m[1][4] = 1'b0; dirty_m[1][4] = 1'b1;
        valid_m[1][5] = 1'b1; dirty_m[1][5] = 1'b0;
        clear_obs();
        start_switch(1'b0, 3);
        run_out(-1);
        check("dirty_busy_len", 32'(last_busy), 32'd17);
        check("dirty_wb_at2", 32'(wb_at[2]), 32'd3);
        check("dirty_wb_at7", 32'(wb_at[7]), 32'd3);
        check("dirty_wb_at4", 32'(wb_at[4]), 32'd0);
        check("dirty_clean_at2", 32'(clean_at[2]), 32'd1);
        check("dirty_clean_at7", 32'(clean_at[7]), 32'd1);
        check("dirty_active", 32'(ACTIVE_BANK), 32'd0);
`ifdef CACHE_SWITCH_STATS_EN
        check("stats_cycles_26", SWITCH_CYCLES, 32'd26);
        check("stats_wb_2", 32'(WB_COUNT), 32'd2);
`endif

        // Asynchronous reset while bank 1 is active.
        start_switch(1'b1, 0);
        run_out(-1);
        check("pre_reset_active", 32'(ACTIVE_BANK), 32'd1);
        async_reset();
        tick(1'b0);
        check("post_reset_active", 32'(ACTIVE_BANK), 32'd0);

        // Same-bank request.
        clear_obs();
        start_switch(1'b0, 0);
        run_out(-1);
        check("same_busy_len", 32'(last_busy), 32'd1);
        check("same_done_pos", 32'(done_at), 32'd1);
        check("same_active", 32'(ACTIVE_BANK), 32'd0);

        // Abuse: request and stray WB_ACK during SCAN are ignored.
        clear_obs();
        start_switch(1'b1, 0);
        run_out(2);
        check("abuse_active", 32'(ACTIVE_BANK), 32'd1);
        check("abuse_busy_len", 32'(last_busy), 32'd9);

        // Reset during WB.
        valid_m[1][3] = 1'b1; dirty_m[1][3] = 1'b1;
        start_switch(1'b0, 4);
        repeat (6) tick(1'b0);
        check("in_wb_before_reset", 32'(WB_REQ), 32'd1);
        async_reset();
        tick(1'b0);
        check("wb_reset_active", 32'(ACTIVE_BANK), 32'd0);

        // Randomized switches with random dirty patterns and ack latencies.
        repeat (40) begin
            for (int s = 0; s < SETS; s++) begin
                valid_m[m_active][s] = 1'($urandom_range(0, 1));
                dirty_m[m_active][s] = 1'($urandom_range(0, 1));
            end
            repeat ($urandom_range(0, 3)) tick(1'b0);
            start_switch(1'($urandom_range(0, 1)), 0);
            run_out(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
